// File: rtl/timer_gp.sv
// General-purpose up-counting timer: prescaler, compare, free-run/periodic/one-shot modes,
// sticky overflow/match flags and a one-cycle irq pulse per flag-set tick.
module timer_gp #(
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_load,
  input  logic [WIDTH-1:0]   i_load_value,
  input  logic [WIDTH-1:0]   i_compare,
  input  logic [PRESC_W-1:0] i_prescale,
  input  logic [1:0]         i_mode,
  input  logic               i_clear_flags,
  output logic [WIDTH-1:0]   o_value,
  output logic               o_overflow,
  output logic               o_match,
  output logic               o_irq,
  output logic               o_running
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               ovf_q, ovf_d;
  logic               match_q, match_d;
  logic               irq_q, irq_d;
  logic               set_ovf, set_match;
  logic               all_ones, hit;

  assign all_ones = (cnt_q == {WIDTH{1'b1}});
  assign hit      = (cnt_q == i_compare);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    presc_d   = presc_q;
    set_ovf   = 1'b0;
    set_match = 1'b0;

    // A load swallows any tick in the same cycle; the loaded value is first compared on the next tick.
    if (i_load) begin
      cnt_d   = i_load_value;
      presc_d = '0;
      state_d = ST_RUN;
    end else if (i_enable && (state_q == ST_RUN)) begin
      if (presc_q == i_prescale) begin
        presc_d = '0;
        case (i_mode)
          2'b01: begin
            if (hit) begin
              cnt_d     = '0;
              set_match = 1'b1;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              set_ovf = all_ones;
            end
          end
          2'b10: begin
            if (hit) begin
              set_match = 1'b1;
              state_d   = ST_DONE;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              set_ovf = all_ones;
            end
          end
          default: begin
            cnt_d     = cnt_q + 1'b1;
            set_ovf   = all_ones;
            set_match = hit;
          end
        endcase
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    // Set beats clear when both happen in the same cycle.
    ovf_d   = set_ovf   | (ovf_q   & ~i_clear_flags);
    match_d = set_match | (match_q & ~i_clear_flags);
    irq_d   = set_ovf | set_match;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      presc_q <= '0;
      ovf_q   <= 1'b0;
      match_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      ovf_q   <= ovf_d;
      match_q <= match_d;
      irq_q   <= irq_d;
    end
  end

  assign o_value    = cnt_q;
  assign o_overflow = ovf_q;
  assign o_match    = match_q;
  assign o_irq      = irq_q;
  assign o_running  = (state_q == ST_RUN);

endmodule

// File: tb/tb_timer_gp.sv
// Directed bench for timer_gp at WIDTH=8: per-cycle vector table plus multi-cycle sequences.
module tb_timer_gp;

  localparam int W  = 8;
  localparam int PW = 4;

  logic          i_clock = 1'b0;
  logic          i_reset, i_enable, i_load, i_clear_flags;
  logic [W-1:0]  i_load_value, i_compare;
  logic [PW-1:0] i_prescale;
  logic [1:0]    i_mode;
  logic [W-1:0]  o_value;
  logic          o_overflow, o_match, o_irq, o_running;

  int n_checks = 0;
  int n_pass   = 0;

  timer_gp #(.WIDTH(W), .PRESC_W(PW)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_load       (i_load),
    .i_load_value (i_load_value),
    .i_compare    (i_compare),
    .i_prescale   (i_prescale),
    .i_mode       (i_mode),
    .i_clear_flags(i_clear_flags),
    .o_value      (o_value),
    .o_overflow   (o_overflow),
    .o_match      (o_match),
    .o_irq        (o_irq),
    .o_running    (o_running)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic          rst, en, ld;
    logic [W-1:0]  lv, cmp;
    logic [PW-1:0] ps;
    logic [1:0]    md;
    logic          clr;
    logic [W-1:0]  e_val;
    logic          e_ovf, e_m, e_irq, e_run;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clk1();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] v, input logic ov,
                           input logic m, input logic irq, input logic run);
    check({tag, "_val"}, 32'(o_value), 32'(v));
    check({tag, "_ovf"}, 32'(o_overflow), 32'(ov));
    check({tag, "_match"}, 32'(o_match), 32'(m));
    check({tag, "_irq"}, 32'(o_irq), 32'(irq));
    check({tag, "_run"}, 32'(o_running), 32'(run));
  endtask

  task automatic idle_inputs();
    i_reset = 0; i_enable = 0; i_load = 0; i_clear_flags = 0;
    i_load_value = '0; i_compare = '0; i_prescale = '0; i_mode = 2'b00;
  endtask

  initial begin
    int irq_cnt;
    idle_inputs();
    i_reset = 1;

    //        rst en ld lv     cmp    ps md     clr  val    ov m  irq run
    vt.push_back('{1, 1, 0, 8'h00, 8'h00, 0, 2'b00, 0, 8'h00, 0, 0, 0, 1}); // 0 reset
    vt.push_back('{0, 1, 0, 8'h00, 8'h02, 0, 2'b01, 0, 8'h01, 0, 0, 0, 1}); // periodic
    vt.push_back('{0, 1, 0, 8'h00, 8'h02, 0, 2'b01, 0, 8'h02, 0, 0, 0, 1});
    vt.push_back('{0, 1, 0, 8'h00, 8'h02, 0, 2'b01, 0, 8'h00, 0, 1, 1, 1}); // period hit
    vt.push_back('{0, 1, 0, 8'h00, 8'h02, 0, 2'b01, 0, 8'h01, 0, 1, 0, 1});
    vt.push_back('{0, 1, 0, 8'h00, 8'h02, 0, 2'b01, 1, 8'h02, 0, 0, 0, 1}); // clear
    vt.push_back('{0, 1, 0, 8'h00, 8'h02, 0, 2'b01, 1, 8'h00, 0, 1, 1, 1}); // set beats clear
    vt.push_back('{0, 0, 0, 8'h00, 8'h02, 0, 2'b01, 0, 8'h00, 0, 1, 0, 1}); // disabled
    vt.push_back('{0, 1, 0, 8'h00, 8'h01, 0, 2'b10, 0, 8'h01, 0, 1, 0, 1}); // one-shot
    vt.push_back('{0, 1, 0, 8'h00, 8'h01, 0, 2'b10, 0, 8'h01, 0, 1, 1, 0}); // -> DONE
    vt.push_back('{0, 1, 0, 8'h00, 8'h01, 0, 2'b10, 0, 8'h01, 0, 1, 0, 0}); // holds
    vt.push_back('{0, 1, 1, 8'h05, 8'h01, 0, 2'b10, 0, 8'h05, 0, 1, 0, 1}); // load re-arms
    vt.push_back('{0, 1, 0, 8'h00, 8'h06, 0, 2'b00, 0, 8'h06, 0, 1, 0, 1}); // free-run
    vt.push_back('{0, 1, 0, 8'h00, 8'h06, 0, 2'b00, 0, 8'h07, 0, 1, 1, 1}); // match, keeps counting
    vt.push_back('{0, 1, 1, 8'hFE, 8'h06, 0, 2'b00, 0, 8'hFE, 0, 1, 0, 1});
    vt.push_back('{0, 1, 0, 8'h00, 8'h06, 0, 2'b00, 1, 8'hFF, 0, 0, 0, 1});
    vt.push_back('{0, 1, 0, 8'h00, 8'h06, 0, 2'b00, 0, 8'h00, 1, 0, 1, 1}); // overflow
    vt.push_back('{0, 1, 1, 8'h40, 8'h00, 0, 2'b00, 0, 8'h40, 1, 0, 0, 1}); // load in match tick
    vt.push_back('{0, 1, 0, 8'h00, 8'h41, 0, 2'b01, 0, 8'h41, 1, 0, 0, 1});
    vt.push_back('{0, 1, 1, 8'h41, 8'h41, 0, 2'b01, 0, 8'h41, 1, 0, 0, 1}); // loaded value not compared
    vt.push_back('{0, 1, 0, 8'h00, 8'h41, 0, 2'b01, 0, 8'h00, 1, 1, 1, 1});
    vt.push_back('{0, 1, 1, 8'hFF, 8'hFF, 0, 2'b00, 1, 8'hFF, 0, 0, 0, 1});
    vt.push_back('{0, 1, 0, 8'h00, 8'hFF, 0, 2'b00, 0, 8'h00, 1, 1, 1, 1}); // both flags, one irq
    vt.push_back('{0, 1, 0, 8'h00, 8'hFF, 0, 2'b00, 0, 8'h01, 1, 1, 0, 1});
    vt.push_back('{0, 1, 1, 8'hFE, 8'h03, 0, 2'b01, 1, 8'hFE, 0, 0, 0, 1}); // above compare
    vt.push_back('{0, 1, 0, 8'h00, 8'h03, 0, 2'b01, 0, 8'hFF, 0, 0, 0, 1});
    vt.push_back('{0, 1, 0, 8'h00, 8'h03, 0, 2'b01, 0, 8'h00, 1, 0, 1, 1}); // wraps first
    vt.push_back('{0, 1, 0, 8'h00, 8'h03, 0, 2'b01, 0, 8'h01, 1, 0, 0, 1});
    vt.push_back('{0, 1, 0, 8'h00, 8'h03, 0, 2'b01, 0, 8'h02, 1, 0, 0, 1});
    vt.push_back('{0, 1, 0, 8'h00, 8'h03, 0, 2'b01, 0, 8'h03, 1, 0, 0, 1});
    vt.push_back('{0, 1, 0, 8'h00, 8'h03, 0, 2'b01, 0, 8'h00, 1, 1, 1, 1}); // then matches
    vt.push_back('{0, 1, 0, 8'h00, 8'h00, 0, 2'b11, 0, 8'h01, 1, 1, 1, 1}); // mode 11 = free-run
    vt.push_back('{1, 1, 1, 8'h55, 8'h00, 0, 2'b01, 0, 8'h00, 0, 0, 0, 1}); // reset wins

    foreach (vt[i]) begin
      i_reset = vt[i].rst; i_enable = vt[i].en; i_load = vt[i].ld;
      i_load_value = vt[i].lv; i_compare = vt[i].cmp; i_prescale = vt[i].ps;
      i_mode = vt[i].md; i_clear_flags = vt[i].clr;
      clk1();
      check_all($sformatf("vec%0d", i), vt[i].e_val, vt[i].e_ovf, vt[i].e_m, vt[i].e_irq, vt[i].e_run);
    end

    // Full 8-bit free-run wrap, compare at 0x80.
    idle_inputs(); i_reset = 1; clk1();
    i_reset = 0; i_enable = 1; i_compare = 8'h80; irq_cnt = 0;
    for (int k = 0; k < 255; k++) begin
      clk1();
      if (o_irq) irq_cnt++;
    end
    check_all("wrap255", 8'hFF, 0, 1, 0, 1);
    clk1();
    if (o_irq) irq_cnt++;
    check_all("wrap256", 8'h00, 1, 1, 1, 1);
    check("wrap_irq_count", 32'(irq_cnt), 32'd2);
    clk1();
    check("wrap_irq_drop", 32'(o_irq), 32'd0);

    // Prescale 3: phase survives an enable gap.
    idle_inputs(); i_reset = 1; clk1();
    i_reset = 0; i_enable = 1; i_prescale = 4'd3; i_compare = 8'hF0;
    repeat (40) clk1();
    check("presc_40", 32'(o_value), 32'd10);
    repeat (2) clk1();
    i_enable = 0;
    repeat (7) clk1();
    check("presc_hold", 32'(o_value), 32'd10);
    i_enable = 1;
    clk1();
    check("presc_phase_a", 32'(o_value), 32'd10);
    clk1();
    check("presc_phase_b", 32'(o_value), 32'd11);

    // Reset from DONE at 0x7A with both flags set.
    idle_inputs(); i_reset = 1; clk1();
    i_reset = 0; i_enable = 1; i_load = 1; i_load_value = 8'hFF; i_compare = 8'h10; clk1();
    i_load = 0; clk1();
    i_load = 1; i_load_value = 8'h79; i_mode = 2'b10; i_compare = 8'h7A; clk1();
    i_load = 0; repeat (2) clk1();
    check_all("done_7a", 8'h7A, 1, 1, 1, 0);
    i_reset = 1; i_prescale = 4'd2; clk1();
    i_reset = 0;
    check_all("rst_done", 8'h00, 0, 0, 0, 1);
    repeat (2) clk1();
    check("rst_no_tick_yet", 32'(o_value), 32'd0);
    clk1();
    check("rst_first_tick", 32'(o_value), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
